cmp_share_arbiter: RTL and testbench

Shares one 4-bit compare unit between two requesters. The compare unit has operand inputs a/b and outputs ans1 (signed a<b) and ans2 (unsigned a<b).
Arbitrates round-robin, latches the winner's operands onto the compare-unit inputs, waits a fixed settle latency, samples both answers and returns them to the winner with a one-cycle ack.
Sits between requesting control logic and the shared comparator in the ALU/branch-decision area.

---
 rtl/cmp_share_arbiter.sv | 122 ++++++++++++
 tb/tb_cmp_share_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that shares one W-bit compare unit between two requesters.
// Optional CMP_EQ_EN adds eq0/eq1 equality results alongside the lt results.
//
// state | meaning
// IDLE  | pick a requester (minus masked port), latch its operands
// WAIT  | count down LAT cycles for the compare unit to settle, then sample
// DONE  | one-cycle ack to the granted port, mask it for the next IDLE cycle
module cmp_share_arbiter #(
  parameter int W   = 4,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  output logic         ack0,
  output logic         lt_s0,
  output logic         lt_u0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack1,
  output logic         lt_s1,
  output logic         lt_u1,
`ifdef CMP_EQ_EN
  output logic         eq0,
  output logic         eq1,
`endif
  output logic [W-1:0] cmp_a,
  output logic [W-1:0] cmp_b,
  input  logic         cmp_ans1,
  input  logic         cmp_ans2,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_CNT = 3'(LAT);

  state_t     state, state_nxt;
  logic       ptr;
  logic       gnt;
  logic [1:0] mask;
  logic [2:0] cnt;
  logic [1:0] cand;
  logic       sel;

  always_comb begin
    state_nxt = state;
    cand      = {req1, req0} & ~mask;
    sel       = ptr;
    if (cand != 2'b11) sel = cand[1];
    case (state)
      IDLE:    if (|cand) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 1'b0;
      gnt   <= 1'b0;
      mask  <= 2'b00;
      cnt   <= '0;
      cmp_a <= '0;
      cmp_b <= '0;
      lt_s0 <= 1'b0;
      lt_u0 <= 1'b0;
      lt_s1 <= 1'b0;
      lt_u1 <= 1'b0;
`ifdef CMP_EQ_EN
      eq0   <= 1'b0;
      eq1   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // The mask only ever covers the single IDLE cycle after a DONE.
          mask <= 2'b00;
          if (|cand) begin
            gnt   <= sel;
            ptr   <= ~sel;
            cmp_a <= sel ? a1 : a0;
            cmp_b <= sel ? b1 : b0;
            cnt   <= LAT_CNT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (gnt) begin
              lt_s1 <= cmp_ans1;
              lt_u1 <= cmp_ans2;
`ifdef CMP_EQ_EN
              eq1   <= (cmp_a == cmp_b);
`endif
            end else begin
              lt_s0 <= cmp_ans1;
              lt_u0 <= cmp_ans2;
`ifdef CMP_EQ_EN
              eq0   <= (cmp_a == cmp_b);
`endif
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE:    mask <= gnt ? 2'b10 : 2'b01;
        default: mask <= 2'b00;
      endcase
    end
  end

  assign ack0 = (state == DONE) && !gnt;
  assign ack1 = (state == DONE) && gnt;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter: four instances with LAT = 0..3, each
// with a behavioural compare unit. Build with CMP_EQ_EN defined to check eq0/eq1.
module tb_cmp_share_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 [4];
  logic       req1 [4];
  logic [3:0] a0 [4];
  logic [3:0] b0 [4];
  logic [3:0] a1 [4];
  logic [3:0] b1 [4];
  logic       ack0 [4];
  logic       ack1 [4];
  logic       lt_s0 [4];
  logic       lt_u0 [4];
  logic       lt_s1 [4];
  logic       lt_u1 [4];
  logic [3:0] cmp_a [4];
  logic [3:0] cmp_b [4];
  logic       ans1 [4];
  logic       ans2 [4];
  logic       busy [4];
`ifdef CMP_EQ_EN
  logic       eq0 [4];
  logic       eq1 [4];
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign ans1[g] = $signed(cmp_a[g]) < $signed(cmp_b[g]);
    assign ans2[g] = cmp_a[g] < cmp_b[g];
    cmp_share_arbiter #(.W(4), .LAT(g)) u_dut (
      .clk(clk), .reset(reset),
      .req0(req0[g]), .a0(a0[g]), .b0(b0[g]),
      .ack0(ack0[g]), .lt_s0(lt_s0[g]), .lt_u0(lt_u0[g]),
      .req1(req1[g]), .a1(a1[g]), .b1(b1[g]),
      .ack1(ack1[g]), .lt_s1(lt_s1[g]), .lt_u1(lt_u1[g]),
`ifdef CMP_EQ_EN
      .eq0(eq0[g]), .eq1(eq1[g]),
`endif
      .cmp_a(cmp_a[g]), .cmp_b(cmp_b[g]),
      .cmp_ans1(ans1[g]), .cmp_ans2(ans2[g]),
      .busy(busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ack0(input int i, input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (ack0[i]) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  k;
    int  both;
    int  a1_seen;
    bit  seen;
    for (int i = 0; i < 4; i++) begin
      req0[i] = 0; req1[i] = 0;
      a0[i] = 0; b0[i] = 0; a1[i] = 0; b1[i] = 0;
    end

    // Test 1: LAT=1, single request from port 0
    do_reset();
    chk("rst_busy", busy[1], 0);
    chk("rst_ack0", ack0[1], 0);
    chk("rst_cmp_a", cmp_a[1], 0);
    chk("rst_lt_u0", lt_u0[1], 0);
    req0[1] = 1; a0[1] = 4'd4; b0[1] = 4'hF;
    tick();
    chk("t1_cmp_a", cmp_a[1], 4);
    chk("t1_cmp_b", cmp_b[1], 4'hF);
    chk("t1_busy1", busy[1], 1);
    tick();
    chk("t1_ack_early", ack0[1], 0);
    chk("t1_busy2", busy[1], 1);
    tick();
    chk("t1_ack0", ack0[1], 1);
    chk("t1_busy3", busy[1], 1);
    chk("t1_lt_s0", lt_s0[1], 0);
    chk("t1_lt_u0", lt_u0[1], 1);
    req0[1] = 0;
    tick();
    chk("t1_ack_off", ack0[1], 0);
    chk("t1_busy4", busy[1], 0);

    // Test 2: simultaneous requests, pointer starts at port 0
    do_reset();
    req0[1] = 1; a0[1] = 4'd4; b0[1] = 4'd7;
    req1[1] = 1; a1[1] = 4'd4; b1[1] = 4'd15;
    tick(); tick(); tick();
    chk("t2_ack0", ack0[1], 1);
    chk("t2_ack1_lo", ack1[1], 0);
    chk("t2_lt_s0", lt_s0[1], 1);
    chk("t2_lt_u0", lt_u0[1], 1);
    req0[1] = 0;
    tick();
    chk("t2_grant1_idle", busy[1], 0);
    tick();
    chk("t2_cmp_b1", cmp_b[1], 15);
    tick(); tick();
    chk("t2_ack1", ack1[1], 1);
    chk("t2_lt_s1", lt_s1[1], 0);
    chk("t2_lt_u1", lt_u1[1], 1);
    req1[1] = 0;
    tick();

    // Test 3: both ports held, strict alternation
    do_reset();
    req0[1] = 1; a0[1] = 4'd1; b0[1] = 4'd2;
    req1[1] = 1; a1[1] = 4'd3; b1[1] = 4'd4;
    k = 0; both = 0;
    for (int c = 0; c < 60 && k < 6; c++) begin
      tick();
      if (ack0[1] && ack1[1]) both++;
      if (ack0[1]) begin
        chk("t3_order", 0, k % 2);
        k++;
      end else if (ack1[1]) begin
        chk("t3_order", 1, k % 2);
        k++;
      end
    end
    chk("t3_acks", k, 6);
    chk("t3_both", both, 0);
    req0[1] = 0; req1[1] = 0;
    tick(); tick();

    // Test 4: LAT=3, reset in second WAIT cycle aborts port 1
    do_reset();
    req1[3] = 1; a1[3] = 4'd5; b1[3] = 4'd6;
    tick();
    chk("t4_busy_wait", busy[3], 1);
    tick();
    reset = 1; req1[3] = 0;
    tick();
    chk("t4_busy_rst", busy[3], 0);
    chk("t4_cmp_a_rst", cmp_a[3], 0);
    chk("t4_lt_s1_rst", lt_s1[3], 0);
    chk("t4_ack1_rst", ack1[3], 0);
    reset = 0;
    req0[3] = 1; a0[3] = 4'd2; b0[3] = 4'd3;
    req1[3] = 1; a1[3] = 4'd5; b1[3] = 4'd6;
    tick();
    chk("t4_grant0", cmp_a[3], 2);
    req0[3] = 0; req1[3] = 0;
    a1_seen = 0; seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      tick();
      if (ack1[3]) a1_seen++;
      if (ack0[3]) seen = 1;
    end
    chk("t4_ack0_seen", seen, 1);
    chk("t4_no_ack1", a1_seen, 0);
    chk("t4_lt_s0", lt_s0[3], 1);
    tick();

    // Test 5: LAT=0, ack two cycles after grant
    do_reset();
    req0[0] = 1; a0[0] = 4'd9; b0[0] = 4'd9;
    tick();
    chk("t5_ack_early", ack0[0], 0);
    tick();
    chk("t5_ack0", ack0[0], 1);
    chk("t5_lt_s0", lt_s0[0], 0);
    chk("t5_lt_u0", lt_u0[0], 0);
`ifdef CMP_EQ_EN
    chk("t5_eq0", eq0[0], 1);
`endif
    a0[0] = 4'd9; b0[0] = 4'd2;
    wait_ack0(0, 10, seen);
    chk("t5_ack0_2", seen, 1);
    chk("t5_lt_u0_2", lt_u0[0], 0);
    chk("t5_lt_s0_2", lt_s0[0], 1);
`ifdef CMP_EQ_EN
    chk("t5_eq0_2", eq0[0], 0);
`endif
    req0[0] = 0;
    tick(); tick();

    // Test 6: LAT=2, port 0 held alone, period LAT+4
    do_reset();
    req0[2] = 1; a0[2] = 4'd1; b0[2] = 4'd2;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("t6_ack_c%0d", c), ack0[2], (c % 6) == 4);
      chk($sformatf("t6_busy_c%0d", c), busy[2], !((c % 6) == 5 || (c % 6) == 0));
    end
    req0[2] = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
